// File: rtl/motoro3_deadtime_guard.sv
// Gate-drive guard for a three-leg inverter: break-before-make dead time per leg,
// shoot-through blocking, force-stop and a sticky fault with capture and event count.

module motoro3_dtg_leg #(
    parameter int DT_CYCLES = 20,
    parameter int DT_W      = 8
) (
    input  logic clk,
    input  logic nRst,
    input  logic raw_h,
    input  logic raw_l,
    input  logic force_off,
    output logic hp,
    output logic lp,
    output logic dead_d
);
    typedef enum logic [1:0] {IDLE, HON, LON, DEAD} leg_state_e;

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT_CYCLES - 1);

    leg_state_e      state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            hp_q, hp_d, lp_q, lp_d;
    logic            want_h, want_l;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= DEAD;
            cnt_q   <= DT_LOAD;
            hp_q    <= 1'b0;
            lp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            lp_q    <= lp_d;
        end
    end

    always_comb begin
        want_h  = raw_h & ~raw_l;
        want_l  = raw_l & ~raw_h;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_off) begin
            state_d = DEAD;
            cnt_d   = DT_LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (want_h)      state_d = HON;
                    else if (want_l) state_d = LON;
                end
                HON: begin
                    if (!want_h) begin
                        state_d = DEAD;
                        cnt_d   = DT_LOAD;
                    end
                end
                LON: begin
                    if (!want_l) begin
                        state_d = DEAD;
                        cnt_d   = DT_LOAD;
                    end
                end
                DEAD: begin
                    // The dead interval always runs to completion before re-arming.
                    if (cnt_q == '0) begin
                        if (want_h)      state_d = HON;
                        else if (want_l) state_d = LON;
                        else             state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = DEAD;
                    cnt_d   = DT_LOAD;
                end
            endcase
        end
        // Gates decode from the next state so the pins come straight off flops.
        hp_d   = (state_d == HON);
        lp_d   = (state_d == LON);
        dead_d = (state_d == DEAD);
    end

    assign hp = hp_q;
    assign lp = lp_q;
endmodule

module motoro3_deadtime_guard #(
    parameter int DT_CYCLES = 20,
    parameter int DT_W      = 8,
    parameter int EVT_W     = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             rawAHp,
    input  logic             rawALp,
    input  logic             rawBHp,
    input  logic             rawBLp,
    input  logic             rawCHp,
    input  logic             rawCLp,
    input  logic             dgStop,
    input  logic             dgFaultClr,
    output logic             aHp,
    output logic             aLp,
    output logic             bHp,
    output logic             bLp,
    output logic             cHp,
    output logic             cLp,
    output logic             dgFault,
    output logic [2:0]       dgFaultLeg,
    output logic [EVT_W-1:0] dgEvtCnt,
    output logic             dgBusy
);
    localparam int NUM_LEGS = 3;

    logic [NUM_LEGS-1:0] raw_h, raw_l, illegal, force_off, hp, lp, dead_d;
    logic                any_ill;
    logic                fault_q, fault_d, busy_q, busy_d;
    logic [NUM_LEGS-1:0] fault_leg_q, fault_leg_d;
    logic [EVT_W-1:0]    evt_q, evt_d;

    assign raw_h     = {rawCHp, rawBHp, rawAHp};
    assign raw_l     = {rawCLp, rawBLp, rawALp};
    assign illegal   = raw_h & raw_l;
    assign any_ill   = |illegal;
    assign force_off = {NUM_LEGS{dgStop | fault_q}} | illegal;

    for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
        motoro3_dtg_leg #(
            .DT_CYCLES (DT_CYCLES),
            .DT_W      (DT_W)
        ) u_leg (
            .clk       (clk),
            .nRst      (nRst),
            .raw_h     (raw_h[i]),
            .raw_l     (raw_l[i]),
            .force_off (force_off[i]),
            .hp        (hp[i]),
            .lp        (lp[i]),
            .dead_d    (dead_d[i])
        );
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fault_q     <= 1'b0;
            fault_leg_q <= '0;
            evt_q       <= '0;
            busy_q      <= 1'b1;
        end else begin
            fault_q     <= fault_d;
            fault_leg_q <= fault_leg_d;
            evt_q       <= evt_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        fault_d     = fault_q;
        fault_leg_d = fault_leg_q;
        // A new illegal request beats a coincident clear.
        if (any_ill) begin
            fault_d = 1'b1;
            if (!fault_q) fault_leg_d = fault_leg_q | illegal;
        end else if (dgFaultClr) begin
            fault_d     = 1'b0;
            fault_leg_d = '0;
        end
        evt_d = evt_q;
        if (any_ill && (evt_q != {EVT_W{1'b1}})) evt_d = evt_q + 1'b1;
        busy_d = |dead_d;
    end

    assign {cHp, bHp, aHp} = hp;
    assign {cLp, bLp, aLp} = lp;
    assign dgFault         = fault_q;
    assign dgFaultLeg      = fault_leg_q;
    assign dgEvtCnt        = evt_q;
    assign dgBusy          = busy_q;
endmodule
